// File: rtl/demux_1_to_4_32bit_buffered.sv
// Registered 1-to-4 word demultiplexer with one-entry holding register per channel
// and independent valid/ready handshakes; counts accepted words for debug.
module demux_1_to_4_32bit_buffered #(
    parameter int unsigned WORD_LENGTH = 32,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LENGTH-1:0] in_data,
    input  logic [1:0]             in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WORD_LENGTH-1:0] out0,
    output logic [WORD_LENGTH-1:0] out1,
    output logic [WORD_LENGTH-1:0] out2,
    output logic [WORD_LENGTH-1:0] out3,
    output logic [3:0]             out_valid,
    input  logic [3:0]             out_ready,
    output logic [CNT_WIDTH-1:0]   accept_count
);

    localparam int unsigned NUM_CH = 4;

    logic [WORD_LENGTH-1:0] data_q [NUM_CH];
    logic [3:0]             valid_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic [3:0]             drain;
    logic                   acc;

    // A full channel can still take a word when its consumer drains in the same cycle.
    assign in_ready = ~rst & (~valid_q[in_sel] | out_ready[in_sel]);
    assign acc      = in_valid & in_ready;
    assign drain    = valid_q & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc && (in_sel == 2'(i))) begin
                    data_q[i]  <= in_data;
                    valid_q[i] <= 1'b1;
                end else if (drain[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (acc) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign out0         = data_q[0];
    assign out1         = data_q[1];
    assign out2         = data_q[2];
    assign out3         = data_q[3];
    assign out_valid    = valid_q;
    assign accept_count = count_q;

endmodule

// File: tb/tb_demux_1_to_4_32bit_buffered.sv
// Self-checking bench: directed and random traffic against a per-channel slot/queue model.
module tb_demux_1_to_4_32bit_buffered;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0, out1, out2, out3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] accept_count;

    int checks = 0;
    int errors = 0;

    // Reference model: what each channel holds, plus words accepted but not yet consumed.
    logic        m_valid [4];
    logic [31:0] m_data  [4];
    logic [31:0] pend    [4][$];
    int          delivered [4];
    logic [15:0] m_cnt;

    demux_1_to_4_32bit_buffered dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out_valid(out_valid), .out_ready(out_ready), .accept_count(accept_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_of(input int i);
        case (i)
            0:       return out0;
            1:       return out1;
            2:       return out2;
            default: return out3;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = 32'h0;
            pend[i].delete();
        end
        m_cnt = 16'h0;
    endtask

    // One clock cycle: called at posedge+1, drives inputs, checks ready and deliveries,
    // advances the model across the edge and checks the registered outputs.
    task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d,
                        input logic [3:0] r, input bit full_check);
        logic exp_rdy;
        logic acc;
        logic [3:0] exp_valid;
        in_valid = v; in_sel = s; in_data = d; out_ready = r;
        #3;
        exp_rdy = !rst && (!m_valid[s] || r[s]);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && r[i]) begin
                if (pend[i].size() == 0) begin
                    chk("deliver_underflow", 64'(1), 64'(0));
                end else begin
                    chk($sformatf("deliver_ch%0d", i), 64'(out_of(i)), 64'(pend[i].pop_front()));
                end
                delivered[i]++;
            end
        end
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc && s == 2'(i)) begin
                m_valid[i] = 1'b1;
                m_data[i]  = d;
                pend[i].push_back(d);
            end else if (m_valid[i] && r[i]) begin
                m_valid[i] = 1'b0;
            end
        end
        if (acc) m_cnt = m_cnt + 16'h1;
        if (full_check) begin
            for (int i = 0; i < 4; i++) exp_valid[i] = m_valid[i];
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            for (int i = 0; i < 4; i++) chk($sformatf("out%0d", i), 64'(out_of(i)), 64'(m_data[i]));
            chk("accept_count", 64'(accept_count), 64'(m_cnt));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out0", 64'(out0), 64'(0));
        chk("rst_out1", 64'(out1), 64'(0));
        chk("rst_out2", 64'(out2), 64'(0));
        chk("rst_out3", 64'(out3), 64'(0));
        chk("rst_count", 64'(accept_count), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0; in_sel = 2'd0; out_ready = 4'b0000;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        int c0;
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 32'h0; out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) delivered[i] = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Routing into four stalled channels.
        step(1'b1, 2'd0, 32'hAAAA0000, 4'b0000, 1'b1);
        step(1'b1, 2'd1, 32'h11111111, 4'b0000, 1'b1);
        step(1'b1, 2'd2, 32'h22222222, 4'b0000, 1'b1);
        step(1'b1, 2'd3, 32'h33333333, 4'b0000, 1'b1);
        chk("route_valid", 64'(out_valid), 64'(4'b1111));
        chk("route_count", 64'(accept_count), 64'(4));
        chk("route_out2", 64'(out2), 64'(32'h22222222));

        // Backpressure on channel 2, then release.
        step(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b1);
        chk("bp_out2_held", 64'(out2), 64'(32'h22222222));
        step(1'b1, 2'd2, 32'hDEADBEEF, 4'b0100, 1'b1);
        chk("bp_out2_new", 64'(out2), 64'(32'hDEADBEEF));
        chk("bp_valid2", 64'(out_valid[2]), 64'(1));

        // Simultaneous drain and load on channel 1.
        step(1'b1, 2'd1, 32'h00000001, 4'b0010, 1'b1);
        c0 = delivered[1];
        step(1'b1, 2'd1, 32'h00000002, 4'b0010, 1'b1);
        chk("sdl_out1", 64'(out1), 64'(32'h2));
        chk("sdl_valid1", 64'(out_valid[1]), 64'(1));
        chk("sdl_seen_once", 64'(delivered[1] - c0), 64'(1));

        // Reset mid-stream with all channels full.
        chk("pre_rst_full", 64'(out_valid), 64'(4'b1111));
        do_reset();

        // Streaming: 100 back-to-back words.
        for (int k = 0; k < 100; k++) begin
            step(1'b1, 2'(k % 4), $urandom, 4'b1111, 1'b1);
        end
        chk("stream_count", 64'(accept_count), 64'(100));

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
                 4'($urandom), 1'b1);
        end

        // Counter wrap.
        do_reset();
        for (int k = 0; k < 65535; k++) begin
            step(1'b1, 2'(k % 4), $urandom, 4'b1111, 1'b0);
        end
        chk("wrap_pre", 64'(accept_count), 64'(16'hFFFF));
        step(1'b1, 2'd0, 32'h12345678, 4'b1111, 1'b1);
        chk("wrap_zero", 64'(accept_count), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
